// File: rtl/uart_rx.sv
// uart_rx: byte-oriented UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined).
// The input line is assumed already synchronized to clk. Each bit is sampled at its middle
// using a single free-running bit timer started on the falling edge of the start bit.
// Received bytes are handed over through a single-entry valid/ready holding register.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit between data and stop).

module uart_rx #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD        = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int unsigned TimerW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [TimerW-1:0] TimerMax  = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [TimerW-1:0] TimerHalf = TimerW'(CLKS_PER_BIT / 2 - 1);

  // Mid-bit sampling needs at least a few clocks per bit to be meaningful.
  if (CLKS_PER_BIT < 4) begin : g_bad_cfg
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;
`endif

  state_e            state_q;
  logic [TimerW-1:0] timer_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic [7:0]        data_q;
  logic              valid_q;
  logic              busy_q;
  logic              frame_err_q;
  logic              overrun_q;
`ifdef UART_RX_PARITY_EN
  logic              parity_err_q;
  logic              parity_bad_q;
`endif

  // Receive FSM, bit timer, shift register and the valid/ready holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      parity_bad_q <= 1'b0;
`endif
    end else begin
      // Error outputs are single-cycle pulses.
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // Handshake drains the holding register; a load later in this block overrides it.
      if (valid_q && i_ready) begin
        valid_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (!i_rx) begin
            state_q <= StStart;
            timer_q <= '0;
            busy_q  <= 1'b1;
          end
        end

        StStart: begin
          if (timer_q == TimerHalf) begin
            if (!i_rx) begin
              state_q   <= StData;
              timer_q   <= '0;
              bit_idx_q <= '0;
            end else begin
              // Start bit vanished before mid-bit: treat as a glitch.
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        StData: begin
          if (timer_q == TimerMax) begin
            timer_q <= '0;
            shift_q <= {i_rx, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (timer_q == TimerMax) begin
            timer_q      <= '0;
            // Even parity: data bits plus parity bit must XOR to zero.
            parity_bad_q <= ^{shift_q, i_rx};
            state_q      <= StStop;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
`endif

        StStop: begin
          if (timer_q == TimerMax) begin
            timer_q <= '0;
            if (!i_rx) begin
              // Framing error wins over parity; wait out a held-low line in StBreak.
              frame_err_q <= 1'b1;
              state_q     <= StBreak;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (parity_bad_q) begin
                parity_err_q <= 1'b1;
              end else if (!valid_q || i_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
`else
              if (!valid_q || i_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
`endif
            end
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        StBreak: begin
          if (i_rx) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed + randomized bench for uart_rx at 16 clocks per bit.
// Frames are built from the line format (start, LSB-first data, optional even parity, stop)
// and expected arrival times follow from the mid-bit sample points.

module tb_uart_rx;

  localparam int C = 16;
  localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif
  // Result appears the cycle after the stop-bit sample.
  localparam int Lat = H + (NBits - 1) * C + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_parity_err;
  logic       o_overrun;
  logic       o_busy;

  uart_rx #(
    .CLK_FREQ_HZ(1_600_000),
    .BAUD       (100_000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_parity_err(o_parity_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts pulse cycles and edges, captures accepted bytes.
  int n_frame = 0, last_frame = 0;
  int n_perr = 0, last_perr = 0;
  int n_ovr = 0;
  int n_vrise = 0, last_vrise = 0;
  int last_bfall = 0;
  logic valid_prev = 1'b0, busy_prev = 1'b0;
  logic [7:0] acc_q[$];

  always @(negedge clk) begin
    #1;
    if (o_frame_err) begin n_frame++; last_frame = cyc; end
    if (o_parity_err) begin n_perr++; last_perr = cyc; end
    if (o_overrun) n_ovr++;
    if (o_valid && !valid_prev) begin n_vrise++; last_vrise = cyc; end
    if (!o_busy && busy_prev) last_bfall = cyc;
    if (o_valid && i_ready) acc_q.push_back(o_data);
    valid_prev = o_valid;
    busy_prev  = o_busy;
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one frame starting at a negedge; t returns the cycle IDLE first sees the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                            input logic ready_at_stop, output int t);
    logic [10:0] fb;
    fb    = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = b[i];
    fb[9]       = (^b) ^ par_flip;
    fb[NBits-1] = stop_bit;
    t = cyc;
    for (int k = 0; k < NBits; k++) begin
      i_rx = fb[k];
      for (int i = 0; i < C; i++) begin
        if (ready_at_stop && k == NBits - 1) begin
          if (i == H) i_ready = 1'b1;
          else if (i == H + 1) i_ready = 1'b0;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic drain();
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  initial begin
    int t, t2, s_frame, s_vrise, s_ovr, s_perr, idx0;
    logic [7:0] b;
    logic [7:0] exp_q[$];

    rst     = 1'b1;
    i_rx    = 1'b1;
    i_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {19'd0, o_data, o_valid, o_busy, o_frame_err, o_parity_err, o_overrun},
        32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single byte, held until drained.
    s_vrise = n_vrise;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, t);
    repeat (40) @(negedge clk);
    chk("single_rise_time", last_vrise - t, Lat);
    chk("single_rise_count", n_vrise - s_vrise, 1);
    chk("single_data", o_data, 8'hA5);
    chk("single_valid_held", o_valid, 1'b1);
    drain();
    chk("single_valid_cleared", o_valid, 1'b0);
    repeat (5) @(negedge clk);

    // Glitch: start bit shorter than half a bit.
    s_vrise = n_vrise;
    s_frame = n_frame;
    i_rx = 1'b0;
    t = cyc;
    repeat (5) @(negedge clk);
    i_rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_busy_fall", last_bfall - t, 9);
    chk("glitch_no_valid", n_vrise - s_vrise, 0);
    chk("glitch_no_frame_err", n_frame - s_frame, 0);

    // Framing error followed by a long break, then a normal byte.
    s_vrise = n_vrise;
    s_frame = n_frame;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, t);
    repeat (100 * C) @(negedge clk);
    chk("break_busy_held", o_busy, 1'b1);
    i_rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("frame_err_count", n_frame - s_frame, 1);
    chk("frame_err_time", last_frame - t, Lat);
    chk("frame_no_valid", n_vrise - s_vrise, 0);
    chk("break_busy_low", o_busy, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, t);
    repeat (10) @(negedge clk);
    chk("after_break_data", {o_valid, o_data}, {1'b1, 8'h5A});
    drain();
    repeat (5) @(negedge clk);

    // Overrun with consumer stalled.
    s_ovr = n_ovr;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, t);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, t2);
    repeat (10) @(negedge clk);
    chk("overrun_count", n_ovr - s_ovr, 1);
    chk("overrun_keeps_old", {o_valid, o_data}, {1'b1, 8'h11});
    drain();
    repeat (5) @(negedge clk);

    // Drain in the completion cycle of the second byte: no overrun, valid stays high.
    s_ovr   = n_ovr;
    s_vrise = n_vrise;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, t);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1, t2);
    repeat (10) @(negedge clk);
    chk("swap_no_overrun", n_ovr - s_ovr, 0);
    chk("swap_new_data", {o_valid, o_data}, {1'b1, 8'h22});
    chk("swap_valid_continuous", n_vrise - s_vrise, 1);
    drain();
    repeat (5) @(negedge clk);

    // Randomized back-to-back bytes with consumer always ready, against a queue model.
    s_ovr   = n_ovr;
    s_frame = n_frame;
    idx0    = acc_q.size();
    i_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      repeat ($urandom_range(0, 1) * $urandom_range(0, 20)) @(negedge clk);
      send_frame(b, 1'b1, 1'b0, 1'b0, t);
    end
    repeat (20) @(negedge clk);
    i_ready = 1'b0;
    chk("rand_count", acc_q.size() - idx0, 8);
    for (int n = 0; n < 8; n++) begin
      chk("rand_byte", (idx0 + n < acc_q.size()) ? acc_q[idx0+n] : 8'hxx, exp_q.pop_front());
    end
    chk("rand_no_errors", (n_ovr - s_ovr) + (n_frame - s_frame), 0);

    // Reset mid-frame with a byte still held.
    send_frame(8'h33, 1'b1, 1'b0, 1'b0, t);
    repeat (5) @(negedge clk);
    b = 8'h7E;
    i_rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      i_rx = b[i];
      repeat (C) @(negedge clk);
    end
    i_rx = b[4];
    repeat (H) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midframe_reset", {19'd0, o_data, o_valid, o_busy, o_frame_err, o_parity_err, o_overrun},
        32'd0);
    @(negedge clk);
    i_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0, t);
    repeat (10) @(negedge clk);
    chk("post_reset_data", {o_valid, o_data}, {1'b1, 8'h7E});
    drain();
    repeat (5) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit, then correct parity bit.
    s_perr  = n_perr;
    s_vrise = n_vrise;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, t);
    repeat (10) @(negedge clk);
    chk("parity_err_count", n_perr - s_perr, 1);
    chk("parity_err_time", last_perr - t, Lat);
    chk("parity_no_valid", n_vrise - s_vrise, 0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, t);
    repeat (10) @(negedge clk);
    chk("parity_ok_data", {o_valid, o_data}, {1'b1, 8'h07});
    drain();
`else
    s_perr = 0;
    chk("parity_err_never", n_perr - s_perr, 0);
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
